fc_mac_serial: RTL and testbench

FC_MAC_SERIAL -- requirements
Module: fc_mac_serial

---
 rtl/fc_pkg.sv | 32 +++
 rtl/fc_mac_lane.sv | 80 ++++++++
 rtl/fc_mac_serial.sv | 113 +++++++++++
 tb/tb_fc_mac_serial.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the serial fully-connected MAC: FSM encoding and width helpers.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
package fc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_BIAS = 2'd2,
    ST_DONE = 2'd3
  } fc_state_t;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Accumulator width: full product width plus enough guard bits that LENGTH
  // products plus the bias can never wrap.
  function automatic int acc_width(input int bitwidth, input int length);
    return 2 * bitwidth + clog2(length) + 1;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output neuron: registered multiply, accumulate, bias add, saturate (ReLU when FC_RELU_EN).
// Latency: product lands in the accumulator one enabled cycle after i_mul_en; result registered on i_fin.
// Backpressure: none; every action is qualified by clken, which freezes all lane state.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int LENGTH   = 25
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clken,
  input  logic                         i_clr,
  input  logic                         i_mul_en,
  input  logic                         i_acc_en,
  input  logic                         i_fin,
  input  logic signed [BITWIDTH-1:0]   i_data,
  input  logic signed [BITWIDTH-1:0]   i_weight,
  input  logic signed [BITWIDTH-1:0]   i_bias,
  output logic signed [2*BITWIDTH-1:0] o_result
);

  localparam int ACCW = acc_width(BITWIDTH, LENGTH);
  localparam int RESW = 2 * BITWIDTH;

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-RESW+1){1'b0}}, {(RESW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-RESW+1){1'b1}}, {(RESW-1){1'b0}}};

  logic signed [RESW-1:0] r_prod;
  logic signed [ACCW-1:0] r_acc;
  logic signed [RESW-1:0] r_result;
  logic signed [RESW-1:0] w_mul;
  logic signed [ACCW-1:0] w_prod_ext;
  logic signed [ACCW-1:0] w_sum;
  logic signed [RESW-1:0] w_sat;

  assign o_result   = r_result;
  assign w_prod_ext = {{(ACCW-RESW){r_prod[RESW-1]}}, r_prod};

  // Full-width signed product, then bias add with saturation to the result width.
  always_comb begin
    w_mul = $signed({{BITWIDTH{i_data[BITWIDTH-1]}}, i_data})
          * $signed({{BITWIDTH{i_weight[BITWIDTH-1]}}, i_weight});
    w_sum = r_acc + $signed({{(ACCW-BITWIDTH){i_bias[BITWIDTH-1]}}, i_bias});
    if (w_sum > SAT_MAX) begin
      w_sat = {1'b0, {(RESW-1){1'b1}}};
    end else if (w_sum < SAT_MIN) begin
      w_sat = {1'b1, {(RESW-1){1'b0}}};
    end else begin
      w_sat = w_sum[RESW-1:0];
    end
`ifdef FC_RELU_EN
    if (w_sat[RESW-1]) begin
      w_sat = '0;
    end
`endif
  end

  // Product pipeline register, accumulator and result register; clken freezes all of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod   <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (clken) begin
      if (i_mul_en) begin
        r_prod <= w_mul;
      end
      if (i_clr) begin
        r_acc <= '0;
      end else if (i_acc_en) begin
        r_acc <= r_acc + w_prod_ext;
      end
      if (i_fin) begin
        r_result <= w_sat;
      end
    end
  end

endmodule

// File: rtl/fc_mac_serial.sv
// Serial fully-connected layer: FILTERBATCH lanes share one data element per cycle over LENGTH cycles.
// Latency: out_valid rises LENGTH+2 enabled cycles after the input handshake (FC_RELU_EN adds ReLU).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; clken=0 freezes everything.
module fc_mac_serial
  import fc_pkg::*;
#(
  parameter int BITWIDTH    = 8,
  parameter int LENGTH      = 25,
  parameter int FILTERBATCH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clken,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [BITWIDTH*LENGTH-1:0]           data,
  input  logic [BITWIDTH*LENGTH*FILTERBATCH-1:0] weight,
  input  logic [BITWIDTH*FILTERBATCH-1:0]      bias,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [2*BITWIDTH*FILTERBATCH-1:0]    result
);

  localparam int IDXW = (clog2(LENGTH) > 0) ? clog2(LENGTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LENGTH - 1);

  fc_state_t                          r_state;
  fc_state_t                          w_state_nxt;
  logic [IDXW-1:0]                    r_idx;
  logic [BITWIDTH*LENGTH-1:0]         r_data;
  logic [BITWIDTH*LENGTH*FILTERBATCH-1:0] r_weight;
  logic [BITWIDTH*FILTERBATCH-1:0]    r_bias;
  logic                               r_pvld;
  logic                               r_out_valid;
  logic                               w_hs;
  logic                               w_mac;
  logic                               w_last;
  logic                               w_fin;
  logic [BITWIDTH-1:0]                w_data_sel;

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = r_out_valid;
  assign w_hs       = in_ready && in_valid;
  assign w_mac      = (r_state == ST_MAC);
  assign w_last     = (r_idx == LAST_IDX);
  // The multiplier is registered, so BIAS spends one cycle letting the last product land.
  assign w_fin      = (r_state == ST_BIAS) && !r_pvld;
  assign w_data_sel = r_data[int'(r_idx)*BITWIDTH +: BITWIDTH];

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_MAC;
      ST_MAC:  if (w_last)    w_state_nxt = ST_BIAS;
      ST_BIAS: if (!r_pvld)   w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // State, element index, product-pending flag and out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_pvld      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (clken) begin
      r_state <= w_state_nxt;
      r_pvld  <= w_mac;
      if (w_hs) begin
        r_idx <= '0;
      end else if (w_mac && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_fin) begin
        r_out_valid <= 1'b1;
      end else if ((r_state == ST_DONE) && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Operand capture on the input handshake; contents are don't-care until then.
  always_ff @(posedge clk) begin
    if (!rst && clken && w_hs) begin
      r_data   <= data;
      r_weight <= weight;
      r_bias   <= bias;
    end
  end

  for (genvar gi = 0; gi < FILTERBATCH; gi++) begin : g_lane
    fc_mac_lane #(
      .BITWIDTH (BITWIDTH),
      .LENGTH   (LENGTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clken    (clken),
      .i_clr    (w_hs),
      .i_mul_en (w_mac),
      .i_acc_en (r_pvld),
      .i_fin    (w_fin),
      .i_data   (w_data_sel),
      .i_weight (r_weight[(gi*LENGTH + int'(r_idx))*BITWIDTH +: BITWIDTH]),
      .i_bias   (r_bias[gi*BITWIDTH +: BITWIDTH]),
      .o_result (result[gi*2*BITWIDTH +: 2*BITWIDTH])
    );
  end

endmodule

// File: tb/tb_fc_mac_serial.sv
// Randomized and directed bench for fc_mac_serial against a dot-product reference model.
// Latency: checks out_valid arrives LENGTH+2 enabled cycles after the input handshake.
// Backpressure: exercises out_ready hold, clken toggling and mid-transaction reset.
module tb_fc_mac_serial;

  localparam int BW = 8;
  localparam int L  = 4;
  localparam int FB = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    clken;
  logic                    in_valid;
  logic                    in_ready;
  logic [BW*L-1:0]         data;
  logic [BW*L*FB-1:0]      weight;
  logic [BW*FB-1:0]        bias;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*BW*FB-1:0]      result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fc_mac_serial #(
    .BITWIDTH    (BW),
    .LENGTH      (L),
    .FILTERBATCH (FB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clken     (clken),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .weight    (weight),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain signed dot product plus bias, clipped to 16-bit signed.
  function automatic longint model(input logic [BW*L-1:0] d, input logic [BW*L*FB-1:0] w,
                                   input logic [BW*FB-1:0] b, input int lane);
    longint acc;
    logic signed [BW-1:0] x;
    logic signed [BW-1:0] y;
    acc = 0;
    for (int j = 0; j < L; j++) begin
      x = d[j*BW +: BW];
      y = w[(lane*L + j)*BW +: BW];
      acc += longint'(x) * longint'(y);
    end
    y = b[lane*BW +: BW];
    acc += longint'(y);
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`ifdef FC_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc;
  endfunction

  function automatic longint lane_res(input int lane);
    logic signed [2*BW-1:0] v;
    v = result[lane*2*BW +: 2*BW];
    return longint'(v);
  endfunction

  task automatic run_txn(input string tag, input logic [BW*L-1:0] d, input logic [BW*L*FB-1:0] w,
                         input logic [BW*FB-1:0] b, input bit toggle, input int hold,
                         output longint r0);
    int lat;
    logic [2*BW*FB-1:0] snap;
    check({tag, " in_ready"}, longint'(in_ready), 1);
    data = d; weight = w; bias = b; in_valid = 1'b1; clken = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data = $urandom; weight = {$urandom, $urandom}; bias = $urandom;
    lat = 0;
    do begin
      if (toggle) clken = ~clken;
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 100);
    clken = 1'b1;
    check({tag, " latency"}, lat, toggle ? 2*(L+2) : L+2);
    for (int i = 0; i < FB; i++) check({tag, " lane"}, lane_res(i), model(d, w, b, i));
    r0 = lane_res(0);
    snap = result;
    for (int k = 0; k < hold; k++) begin
      in_valid = (k == hold/2);
      data = $urandom; weight = {$urandom, $urandom}; bias = $urandom;
      @(posedge clk); #1;
      check({tag, " hold out_valid"}, longint'(out_valid), 1);
      check({tag, " hold in_ready"}, longint'(in_ready), 0);
      check({tag, " hold result"}, longint'(result), longint'(snap));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " post out_valid"}, longint'(out_valid), 0);
    check({tag, " post in_ready"}, longint'(in_ready), 1);
    check({tag, " post result"}, longint'(result), longint'(snap));
  endtask

  initial begin
    longint r;
    logic [BW*L-1:0]    rd;
    logic [BW*L*FB-1:0] rw;
    logic [BW*FB-1:0]   rb;

    rst = 1'b1; clken = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data = '0; weight = '0; bias = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset in_ready", longint'(in_ready), 1);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset result", longint'(result), 0);

    run_txn("basic", {4{8'd1}}, {8{8'd2}}, {2{8'd3}}, 1'b0, 0, r);
    check("basic value", r, 11);

    run_txn("satpos", {4{8'd127}}, {8{8'd127}}, '0, 1'b0, 0, r);
    check("satpos value", r, 32767);

    run_txn("satneg", {4{8'h80}}, {8{8'd127}}, '0, 1'b0, 0, r);
`ifdef FC_RELU_EN
    check("satneg value", r, 0);
`else
    check("satneg value", r, -32768);
`endif

    // Long DONE hold with a stray in_valid pulse; the pulse must not start a transaction.
    run_txn("hold", {4{8'd1}}, {8{8'd2}}, {2{8'd3}}, 1'b0, 10, r);
    repeat (8) @(posedge clk);
    #1;
    check("stray out_valid", longint'(out_valid), 0);
    check("stray in_ready", longint'(in_ready), 1);

    run_txn("clken", {4{8'd1}}, {8{8'd2}}, {2{8'd3}}, 1'b1, 0, r);
    check("clken value", r, 11);

    // Reset during the second MAC cycle.
    data = {4{8'd5}}; weight = {8{8'd7}}; bias = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst out_valid", longint'(out_valid), 0);
    check("rst in_ready", longint'(in_ready), 1);
    check("rst result", longint'(result), 0);
    run_txn("after_rst", {4{8'd1}}, {8{8'd2}}, {2{8'd3}}, 1'b0, 0, r);
    check("after_rst value", r, 11);

    run_txn("neg", {4{8'd1}}, {8{8'hFF}}, {2{8'hFA}}, 1'b0, 0, r);
`ifdef FC_RELU_EN
    check("neg value", r, 0);
`else
    check("neg value", r, -10);
`endif

    for (int t = 0; t < 20; t++) begin
      rd = $urandom;
      rw = {$urandom, $urandom};
      rb = $urandom;
      run_txn("rand", rd, rw, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
